// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
// Decides, from the instructions currently in ID and EX, whether the PC and
// the IF/ID register hold, and whether IF/ID or ID/EX receive a bubble at the
// next edge. It also tracks multi-cycle mult/div occupancy of EX and keeps a
// saturating count of PC-stall cycles for performance debug.
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs_i,
  input  logic [4:0]       ID_Rt_i,
  input  logic             ID_UsesRs_i,
  input  logic             ID_UsesRt_i,
  input  logic             ID_Jump_i,
  input  logic             ID_JumpReg_i,
  input  logic             ID_MulDiv_i,
  input  logic             EX_MemRead_i,
  input  logic             EX_RegWr_i,
  input  logic [4:0]       EX_WriteReg_i,
  input  logic             EX_BranchTaken_i,
  output logic             PC_Stall_o,
  output logic             IFID_Stall_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Flush_o,
  output logic             MD_Busy_o,
  output logic [CNT_W-1:0] StallCnt_o
);

  localparam logic [0:0]       ST_RUN    = 1'b0;
  localparam logic [0:0]       ST_MDBUSY = 1'b1;
  // md_cnt is loaded with the number of busy cycles that follow the issue edge
  localparam logic [3:0]       MD_START  = 4'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic wr_nz;
  logic dep;
  logic loaduse;
  logic jrdep;
  logic pc_stall;
  logic ifid_flush;
  logic idex_flush;
  logic md_busy;

  // Register-dependency terms between the ID consumer and the EX producer ($0 never hazards)
  always_comb begin
    wr_nz   = (EX_WriteReg_i != 5'd0);
    dep     = wr_nz & ((ID_UsesRs_i & (ID_Rs_i == EX_WriteReg_i)) |
                       (ID_UsesRt_i & (ID_Rt_i == EX_WriteReg_i)));
    loaduse = EX_MemRead_i & dep;
    // jr/jalr read rs already in ID, so any pending EX write of rs must drain first
    jrdep   = ID_JumpReg_i & EX_RegWr_i & wr_nz & (ID_Rs_i == EX_WriteReg_i);
  end

  // Prioritised control decision (Mealy) and next-state selection
  always_comb begin
    pc_stall   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_busy    = 1'b0;
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    if (reset) begin
      // Outputs stay quiet during reset; the flops clear themselves below
      state_d  = ST_RUN;
      md_cnt_d = 4'd0;
    end else if (state_q == ST_MDBUSY) begin
      // EX is occupied by the mult/div, so a branch-taken indication cannot be real here
      pc_stall   = 1'b1;
      idex_flush = 1'b1;
      md_busy    = 1'b1;
      md_cnt_d   = md_cnt_q - 4'd1;
      if (md_cnt_q <= 4'd1) begin
        state_d = ST_RUN;
      end
    end else if (EX_BranchTaken_i) begin
      // Wrong-path instructions in IF and ID are killed; whatever ID wanted is moot
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (loaduse | jrdep) begin
      pc_stall   = 1'b1;
      idex_flush = 1'b1;
    end else if (ID_MulDiv_i) begin
      state_d  = ST_MDBUSY;
      md_cnt_d = MD_START;
    end else if (ID_Jump_i) begin
      ifid_flush = 1'b1;
    end
  end

  // Saturating stall-cycle counter: increment and saturation share one edge
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, mult/div countdown and stall counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // IF/ID holds exactly when the PC holds, so a flush can never coincide with a hold
  assign PC_Stall_o   = pc_stall;
  assign IFID_Stall_o = pc_stall;
  assign IFID_Flush_o = ifid_flush;
  assign IDEX_Flush_o = idex_flush;
  assign MD_Busy_o    = md_busy;
  assign StallCnt_o   = stall_cnt_q;

endmodule
